serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder built around a single full_adder instance, with a carry flip-flop feeding cout back into cin on each cycle.
- Processes one bit per clock, LSB first, using operand shift registers, a bit counter and a start/busy/done handshake.
- It is the sequential stage that consumes the full adder's sum/cout each cycle.
- It is the area-minimal adder option of the library, alongside the parallel ripple adders.

---
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder plus a carry flip-flop, LSB first,
// with a start/busy/done handshake and registered result outputs.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_shift;
  logic             load;

  full_adder u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts
  assign acc_shift = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: load = start;
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          sum_d   = acc_shift;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        load    = start;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Result registers are left untouched on accept so the last result stays visible
    if (load) begin
      state_d = S_RUN;
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      carry_d = cin;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed handshake scenarios on an 8-bit instance and
// randomized additions on 1-, 8- and 16-bit instances against an arithmetic model.

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        st1 = 1'b0, c1 = 1'b0, busy1, done1, cout1;
  logic [0:0]  a1 = '0, b1 = '0, sum1;
  logic        st8 = 1'b0, c8 = 1'b0, busy8, done8, cout8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        st16 = 1'b0, c16 = 1'b0, busy16, done16, cout16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(c16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  function automatic int wd(input int s);
    case (s)
      0:       return 1;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  // Reference: unsigned a+b+cin truncated to WIDTH+1 bits
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    logic [31:0] mask;
    mask = (32'd1 << (w + 1)) - 32'd1;
    return (32'(a) + 32'(b) + 32'(c)) & mask;
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0:       return done1;
      1:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic get_busy(input int s);
    case (s)
      0:       return busy1;
      1:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int s);
    case (s)
      0:       return {30'd0, cout1, sum1};
      1:       return {23'd0, cout8, sum8};
      default: return {15'd0, cout16, sum16};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int s, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    case (s)
      0:       begin st1 = st;  a1 = a[0:0];  b1 = b[0:0];  c1 = c;  end
      1:       begin st8 = st;  a8 = a[7:0];  b8 = b[7:0];  c8 = c;  end
      default: begin st16 = st; a16 = a;      b16 = b;      c16 = c; end
    endcase
  endtask

  // Returns at the first falling edge after the accepting clock edge
  task automatic start_op(input int s, input logic [15:0] a, input logic [15:0] b, input logic c);
    drive(s, 1'b1, a, b, c);
    tick();
    drive(s, 1'b0, a, b, c);
  endtask

  task automatic wait_done(input int s, input string tag);
    int cyc;
    cyc = 0;
    while (!get_done(s) && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(wd(s)));
  endtask

  task automatic op(input int s, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input string tag);
    start_op(s, a, b, c);
    wait_done(s, tag);
    check({tag, "_result"}, get_res(s), model(wd(s), a, b, c));
    tick();
    check({tag, "_done_fell"}, 32'(get_done(s)), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;
    logic [15:0] ra, rb;
    logic        rc;
    logic [15:0] amask;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("reset_busy", 32'(get_busy(s)), 32'd0);
      check("reset_done", 32'(get_done(s)), 32'd0);
      check("reset_result", get_res(s), 32'd0);
    end

    // Basic add with busy/latency observation
    start_op(1, 16'h5A, 16'h3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("basic_busy_high", 32'(busy8), 32'd1);
      check("basic_no_early_done", 32'(done8), 32'd0);
      tick();
    end
    check("basic_done", 32'(done8), 32'd1);
    check("basic_busy_low", 32'(busy8), 32'd0);
    check("basic_result", get_res(1), 32'h096);
    tick();
    check("basic_done_fell", 32'(done8), 32'd0);
    check("basic_result_held", get_res(1), 32'h096);

    op(1, 16'hFF, 16'h01, 1'b0, "ripple");
    op(1, 16'hFF, 16'hFF, 1'b1, "allones");
    op(1, 16'h00, 16'h00, 1'b0, "no_carry_leak");

    // Start during RUN must be ignored
    start_op(1, 16'h10, 16'h20, 1'b0);
    tick();
    tick();
    drive(1, 1'b1, 16'hFF, 16'h20, 1'b0);
    tick();
    drive(1, 1'b0, 16'hFF, 16'h20, 1'b0);
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      if (done8) begin
        pulses++;
        seen = get_res(1);
      end
      tick();
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_result", seen, 32'h030);

    // Reset in the middle of RUN aborts the addition
    start_op(1, 16'h12, 16'h34, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_result", get_res(1), 32'd0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (done8) pulses++;
      tick();
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    op(1, 16'hA5, 16'h5B, 1'b1, "after_rst");

    // Start held across the DONE cycle
    start_op(1, 16'h5A, 16'h3C, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    drive(1, 1'b1, 16'h81, 16'h7F, 1'b0);
    tick();
    check("b2b_first_done", 32'(done8), 32'd1);
    check("b2b_first_result", get_res(1), 32'h096);
    tick();
    drive(1, 1'b0, 16'h81, 16'h7F, 1'b0);
    check("b2b_done_fell", 32'(done8), 32'd0);
    check("b2b_busy_again", 32'(busy8), 32'd1);
    check("b2b_result_held", get_res(1), 32'h096);
    wait_done(1, "b2b_second");
    check("b2b_second_result", get_res(1), 32'h100);
    tick();

    // Randomized regression across widths
    for (int s = 0; s < 3; s++) begin
      amask = 16'((32'd1 << wd(s)) - 32'd1);
      for (int i = 0; i < 334; i++) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        ra = 16'($urandom) & amask;
        rb = 16'($urandom) & amask;
        rc = 1'($urandom);
        op(s, ra, rb, rc, "random");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
